// File: rtl/block_allocator.sv
// block_allocator
//   Hands out physical page addresses {block, page} from an open block that
//   is filled sequentially. Fresh blocks are popped from an external
//   clean-block FIFO. Host writes receive one page per cycle; garbage
//   collection relocations (moves) take priority and are handed to a
//   page-copy datapath, holding the copy request until it is acknowledged.
//
// Ports
//   CLK, RST        clock (rising edge) and asynchronous active-high reset
//   active_blk      head of the clean-block FIFO
//   clean_num       number of clean blocks in the FIFO
//   active_request  one-cycle pulse popping the FIFO head
//   write_req       host page request (level)
//   write_grant     one-cycle grant, write_addr valid in the same cycle
//   write_addr      granted page {block, page}
//   gc_request      GC active, host grants blocked
//   move_flag       GC relocation request, move_src stable while high
//   move_src        source page of the relocation
//   move_done_flag  one-cycle pulse, relocation complete
//   copy_req        copy request, held until copy_ack
//   copy_src/dst    copy addresses
//   copy_ack        datapath finished the copy
//   open_blk        block currently being filled
//   free_pages      unallocated pages left in open_blk
//   stall           no open block available
module block_allocator #(
    parameter int BLOCK_W = 10,
    parameter int PAGE_W  = 6,
    parameter int CNT_W   = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [BLOCK_W-1:0]        active_blk,
    input  logic [CNT_W-1:0]          clean_num,
    output logic                      active_request,
    input  logic                      write_req,
    output logic                      write_grant,
    output logic [BLOCK_W+PAGE_W-1:0] write_addr,
    input  logic                      gc_request,
    input  logic                      move_flag,
    input  logic [BLOCK_W+PAGE_W-1:0] move_src,
    output logic                      move_done_flag,
    output logic                      copy_req,
    output logic [BLOCK_W+PAGE_W-1:0] copy_src,
    output logic [BLOCK_W+PAGE_W-1:0] copy_dst,
    input  logic                      copy_ack,
    output logic [BLOCK_W-1:0]        open_blk,
    output logic [PAGE_W:0]           free_pages,
    output logic                      stall
);

    localparam int ADDR_W = BLOCK_W + PAGE_W;
    localparam logic [PAGE_W-1:0] LAST_PAGE = '1;
    localparam logic [PAGE_W:0]   PAGES     = {1'b1, {PAGE_W{1'b0}}};

    typedef enum logic [1:0] {
        LOAD,
        READY,
        MOVE_WAIT,
        REFILL
    } state_t;

    state_t              state_q, state_d;
    logic [PAGE_W-1:0]   page_q,  page_d;
    logic [BLOCK_W-1:0]  open_q,  open_d;
    logic [ADDR_W-1:0]   src_q,   src_d;
    logic [ADDR_W-1:0]   dst_q,   dst_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= LOAD;
            page_q  <= '0;
            open_q  <= '0;
            src_q   <= '0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            open_q  <= open_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        page_d         = page_q;
        open_d         = open_q;
        src_d          = src_q;
        dst_d          = dst_q;
        active_request = 1'b0;
        write_grant    = 1'b0;
        move_done_flag = 1'b0;

        unique case (state_q)
            LOAD, REFILL: begin
                // RST gating keeps the pop pulse quiet while reset holds LOAD.
                if (clean_num != '0 && !RST) begin
                    active_request = 1'b1;
                    open_d         = active_blk;
                    page_d         = '0;
                    state_d        = READY;
                end
            end
            READY: begin
                if (move_flag) begin
                    src_d   = move_src;
                    dst_d   = {open_q, page_q};
                    state_d = MOVE_WAIT;
                end else if (write_req && !gc_request) begin
                    write_grant = 1'b1;
                    // Last page: park the pointer and fetch a new block.
                    if (page_q == LAST_PAGE) begin
                        state_d = REFILL;
                    end else begin
                        page_d = page_q + 1'b1;
                    end
                end
            end
            MOVE_WAIT: begin
                if (copy_ack) begin
                    move_done_flag = 1'b1;
                    if (page_q == LAST_PAGE) begin
                        state_d = REFILL;
                    end else begin
                        page_d  = page_q + 1'b1;
                        state_d = READY;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign stall      = (state_q == LOAD) || (state_q == REFILL);
    assign copy_req   = (state_q == MOVE_WAIT);
    assign copy_src   = src_q;
    assign copy_dst   = dst_q;
    assign write_addr = {open_q, page_q};
    assign open_blk   = open_q;
    assign free_pages = stall ? '0 : (PAGES - {1'b0, page_q});

endmodule

// File: tb/tb_block_allocator.sv
module tb_block_allocator;

    localparam int BLOCK_W = 10;
    localparam int PAGE_W  = 6;
    localparam int CNT_W   = 4;
    localparam int ADDR_W  = BLOCK_W + PAGE_W;
    localparam int NPAGES  = 64;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic [BLOCK_W-1:0] active_blk = '0;
    logic [CNT_W-1:0]   clean_num = '0;
    logic               active_request;
    logic               write_req = 1'b0;
    logic               write_grant;
    logic [ADDR_W-1:0]  write_addr;
    logic               gc_request = 1'b0;
    logic               move_flag = 1'b0;
    logic [ADDR_W-1:0]  move_src = '0;
    logic               move_done_flag;
    logic               copy_req;
    logic [ADDR_W-1:0]  copy_src;
    logic [ADDR_W-1:0]  copy_dst;
    logic               copy_ack = 1'b0;
    logic [BLOCK_W-1:0] open_blk;
    logic [PAGE_W:0]    free_pages;
    logic               stall;

    block_allocator #(.BLOCK_W(BLOCK_W), .PAGE_W(PAGE_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .active_blk(active_blk), .clean_num(clean_num), .active_request(active_request),
        .write_req(write_req), .write_grant(write_grant), .write_addr(write_addr),
        .gc_request(gc_request), .move_flag(move_flag), .move_src(move_src),
        .move_done_flag(move_done_flag), .copy_req(copy_req),
        .copy_src(copy_src), .copy_dst(copy_dst), .copy_ack(copy_ack),
        .open_blk(open_blk), .free_pages(free_pages), .stall(stall)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [ADDR_W-1:0] mk(input logic [BLOCK_W-1:0] b, input int p);
        return {b, PAGE_W'(p)};
    endfunction

    // Clean-block FIFO environment plus scoreboard queues
    logic [BLOCK_W-1:0] fifo[$];
    logic [BLOCK_W-1:0] exp_blk[$];   // expected pop order
    logic [ADDR_W-1:0]  exp_move[$];  // expected copy sources, in issue order
    int pops_seen = 0;
    int pops_done = 0;

    task automatic drive_fifo();
        active_blk = (fifo.size() != 0) ? fifo[0] : '0;
        clean_num  = (fifo.size() > 15) ? CNT_W'(15) : CNT_W'(fifo.size());
    endtask

    task automatic push_blk(input logic [BLOCK_W-1:0] b);
        fifo.push_back(b);
        exp_blk.push_back(b);
        drive_fifo();
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        while (pops_done < pops_seen) begin
            if (fifo.size() != 0) void'(fifo.pop_front());
            pops_done++;
        end
        drive_fifo();
    endtask

    task automatic wait_copy_req(input string name);
        int n;
        n = 0;
        while (!copy_req && n < 300) begin
            tick();
            n++;
        end
        if (!copy_req) chk(name, copy_req, 1);
    endtask

    // Reference model: the open block is filled page by page in FIFO order;
    // each grant or completed move consumes the next page.
    bit                 have_blk = 0;
    bit                 in_move  = 0;
    int                 page     = 0;
    logic [BLOCK_W-1:0] cur_blk  = '0;
    logic [ADDR_W-1:0]  cap_src  = '0;
    logic [ADDR_W-1:0]  cap_dst  = '0;

    always @(negedge CLK) begin : monitor
        bit eg, start_mv, done_mv, exp_pop;
        if (active_request) pops_seen++;
        if (RST) begin
            chk("rst_copy_req", copy_req, 0);
            chk("rst_write_grant", write_grant, 0);
            chk("rst_move_done", move_done_flag, 0);
            chk("rst_active_request", active_request, 0);
            chk("rst_stall", stall, 1);
            have_blk = 0;
            in_move  = 0;
        end else begin
            eg       = have_blk && !in_move && !move_flag && write_req && !gc_request;
            start_mv = have_blk && !in_move && move_flag;
            done_mv  = in_move && copy_ack;
            exp_pop  = !have_blk && (clean_num != 0);

            chk("stall", stall, !have_blk);
            chk("free_pages", free_pages, have_blk ? NPAGES - page : 0);
            if (have_blk) chk("open_blk", open_blk, cur_blk);
            chk("copy_req", copy_req, in_move);
            if (in_move) begin
                chk("copy_src", copy_src, cap_src);
                chk("copy_dst", copy_dst, cap_dst);
            end
            chk("write_grant", write_grant, eg);
            chk("move_done_flag", move_done_flag, done_mv);
            chk("active_request", active_request, exp_pop);

            if (exp_pop) begin
                if (exp_blk.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL blk_queue: pop expected with empty block queue (t=%0t)", $time);
                end else begin
                    cur_blk  = exp_blk.pop_front();
                    have_blk = 1;
                    page     = 0;
                end
            end else if (eg) begin
                chk("write_addr", write_addr, mk(cur_blk, page));
                page++;
                if (page == NPAGES) have_blk = 0;
            end else if (start_mv) begin
                in_move = 1;
                cap_dst = mk(cur_blk, page);
                if (exp_move.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL move_queue: move start with no issued move (t=%0t)", $time);
                end else begin
                    cap_src = exp_move.pop_front();
                end
            end else if (done_mv) begin
                in_move = 0;
                page++;
                if (page == NPAGES) have_blk = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        bit mv_pending, mv_active;

        // Reset with an empty FIFO, then three clean blocks
        repeat (3) tick();
        push_blk(10'h005);
        push_blk(10'h009);
        push_blk(10'h00C);
        tick();
        RST = 1'b0;
        tick();
        chk("first_open_blk", open_blk, 10'h005);
        chk("first_free_pages", free_pages, 64);
        chk("first_stall", stall, 0);

        // Move and write in the same cycle: move wins, dst is page 0
        write_req = 1'b1;
        move_flag = 1'b1;
        move_src  = mk(10'h002, 7);
        exp_move.push_back(move_src);
        tick();
        chk("move_dst_page0", copy_dst, 16'h0140);
        chk("move_src_latched", copy_src, 16'h0087);
        move_flag = 1'b0;
        repeat (4) tick();
        copy_ack = 1'b1;
        tick();
        copy_ack = 1'b0;
        chk("grant_after_move", write_addr, 16'h0141);

        // Fill the rest of block 5 and roll into block 9
        repeat (70) tick();

        // GC blocks host grants for 10 cycles
        gc_request = 1'b1;
        repeat (10) tick();
        gc_request = 1'b0;
        tick();

        // Drain everything, stall with an empty FIFO, then refill
        n = 0;
        while (!(stall && clean_num == 0) && n < 400) begin
            tick();
            n++;
        end
        if (!(stall && clean_num == 0)) chk("drain_to_stall", stall, 1);
        repeat (5) tick();
        push_blk(10'h011);
        repeat (5) tick();

        // Randomised traffic
        mv_pending = 0;
        mv_active  = 0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (fifo.size() < 3 && $urandom_range(0, 3) == 0)
                push_blk(BLOCK_W'($urandom_range(1, 1023)));
            write_req  = ($urandom_range(0, 3) != 0);
            gc_request = ($urandom_range(0, 7) == 0);
            copy_ack   = 1'b0;
            if (mv_pending) begin
                if (copy_req) begin
                    move_flag  = 1'b0;
                    mv_pending = 0;
                    mv_active  = 1;
                end
            end else if (mv_active) begin
                if ($urandom_range(0, 3) == 0) begin
                    copy_ack  = 1'b1;
                    mv_active = 0;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                move_src   = ADDR_W'($urandom);
                move_flag  = 1'b1;
                exp_move.push_back(move_src);
                mv_pending = 1;
            end else begin
                copy_ack = ($urandom_range(0, 7) == 0);
            end
        end
        write_req  = 1'b0;
        gc_request = 1'b0;
        copy_ack   = 1'b0;
        if (fifo.size() == 0) push_blk(10'h3A0);
        if (mv_pending) begin
            wait_copy_req("rand_move_accept");
            move_flag = 1'b0;
            mv_active = 1;
        end
        if (mv_active) begin
            tick();
            copy_ack = 1'b1;
            tick();
            copy_ack = 1'b0;
        end
        repeat (3) tick();

        // Reset in the middle of a copy
        if (fifo.size() == 0) push_blk(10'h155);
        push_blk(10'h2AA);
        move_src  = mk(10'h033, 5);
        move_flag = 1'b1;
        exp_move.push_back(move_src);
        wait_copy_req("reset_move_accept");
        move_flag = 1'b0;
        repeat (2) tick();
        RST = 1'b1;
        #1;
        chk("async_rst_copy_req", copy_req, 0);
        chk("async_rst_stall", stall, 1);
        tick();
        copy_ack = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        copy_ack = 1'b0;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
